// File: rtl/sha256_msg_schedule_pkg.sv
// sha256_msg_schedule_pkg: shared states, widths and sigma rotate/shift amounts
package sha256_msg_schedule_pkg;
  typedef enum logic {LOAD, EXPAND} state_t;
  localparam int WORD_W = 32;
  localparam int N_IN = 16;
  localparam int N_OUT = 64;
  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;
endpackage

// File: rtl/sha256_sigma.sv
// sha256_sigma: SHA-256 small sigma (SEL 0 = sigma0, 1 = sigma1) as fixed rewiring
module sha256_sigma
  import sha256_msg_schedule_pkg::*;
#(
  parameter int SEL = 0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);
  localparam int R1 = SEL ? S1_R1 : S0_R1;
  localparam int R2 = SEL ? S1_R2 : S0_R2;
  localparam int SH = SEL ? S1_SH : S0_SH;
  // constant-amount rotates and logical shift, xor-combined
  always_comb
    y = ((x >> R1) | (x << (WORD_W - R1))) ^ ((x >> R2) | (x << (WORD_W - R2))) ^ (x >> SH);
endmodule

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule: loads 16 message words, then emits W[0..63] via a 16-word sliding window
module sha256_msg_schedule
  import sha256_msg_schedule_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [5:0]        out_index,
  output logic              busy
);
  state_t state, state_next;
  logic [5:0] cnt, cnt_next;
  logic [WORD_W-1:0] win [N_IN];
  logic [WORD_W-1:0] s0, s1, new_word;
  logic in_fire, out_fire;
  sha256_sigma #(.SEL(0)) u_s0 (.x(win[1]), .y(s0));
  sha256_sigma #(.SEL(1)) u_s1 (.x(win[14]), .y(s1));
  // handshakes, outputs and next state/count
  always_comb begin
    in_ready = state == LOAD;
    out_valid = state == EXPAND;
    busy = state != LOAD;
    out_word = win[0];
    out_index = cnt;
    in_fire = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    new_word = cnt <= 6'd47 ? s1 + win[9] + s0 + win[0] : '0;
    cnt_next = in_fire ? (cnt == 6'(N_IN - 1) ? 6'd0 : cnt + 6'd1) : out_fire ? cnt + 6'd1 : cnt;
    state_next = in_fire && cnt == 6'(N_IN - 1) ? EXPAND : out_fire && cnt == 6'(N_OUT - 1) ? LOAD : state;
  end
  // state, counter and window registers; window shifts on every transfer
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= LOAD;
      cnt <= '0;
      for (int i = 0; i < N_IN; i++) win[i] <= '0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      if (in_fire || out_fire) begin
        for (int i = 0; i < N_IN - 1; i++) win[i] <= win[i+1];
        win[N_IN-1] <= in_fire ? in_word : new_word;
      end
    end
endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb_sha256_msg_schedule: randomized self-checking bench against an array-based schedule model
module tb_sha256_msg_schedule;
  logic clock = 0, reset_n = 0, in_valid = 0, out_ready = 0, in_ready, out_valid, busy;
  logic [31:0] in_word = 0, out_word;
  logic [5:0] out_index;
  int errors = 0, checks = 0;
  logic [31:0] got [64];
  logic [31:0] blk [16];
  logic [31:0] exp_w [64];

  sha256_msg_schedule dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_index(out_index), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  task automatic model(input logic [31:0] b [16], output logic [31:0] w [64]);
    for (int t = 0; t < 64; t++)
      if (t < 16) w[t] = b[t];
      else if (t < 64) begin
        logic [31:0] a, c;
        a = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
        c = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
        w[t] = c + w[t-7] + a + w[t-16];
      end
  endtask

  // Call at a negedge; returns at the negedge after the 16th accepted word.
  task automatic load_block(input logic [31:0] b [16], input bit gaps);
    int n = 0, cyc = 0;
    bit tog = 1, fire;
    while (n < 16 && cyc < 200) begin
      in_valid = gaps ? tog : 1'b1;
      in_word = b[n];
      tog = !tog;
      chk("load_ov_low", {31'd0, out_valid}, 32'd0);
      fire = in_valid && in_ready;
      @(posedge clock);
      @(negedge clock);
      if (fire) n++;
      cyc++;
    end
    in_valid = 0;
    chk("load_count", n, 16);
    if (gaps) chk("load_gap_cycles", cyc, 31);
    chk("load_ov_rise", {31'd0, out_valid}, 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    chk("load_ir_low", {31'd0, in_ready}, 32'd0);
  endtask

  // Call at a negedge; consumes words until index stop is reached.
  task automatic drain(input logic [31:0] w [64], input bit rnd, input int stop);
    int idx = 0, cyc = 0;
    bit fire;
    while (idx < stop && cyc < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("ov", {31'd0, out_valid}, 32'd1);
      chk("word", out_word, w[idx]);
      chk("index", {26'd0, out_index}, idx);
      got[idx] = out_word;
      fire = out_ready && out_valid;
      @(posedge clock);
      @(negedge clock);
      if (fire) idx++;
      cyc++;
    end
    out_ready = 0;
    chk("drain_count", idx, stop);
    if (stop == 64) begin
      chk("done_ir", {31'd0, in_ready}, 32'd1);
      chk("done_ov", {31'd0, out_valid}, 32'd0);
      chk("done_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic rand_block();
    foreach (blk[i]) blk[i] = 32'($urandom);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ir", {31'd0, in_ready}, 32'd1);
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_word", out_word, 32'd0);
    chk("rst_index", {26'd0, out_index}, 32'd0);
    reset_n = 1;
    @(negedge clock);
    foreach (blk[i]) blk[i] = 0;
    blk[0] = 32'h61626380;
    blk[15] = 32'h00000018;
    model(blk, exp_w);
    load_block(blk, 0);
    drain(exp_w, 0, 64);
    chk("abc_w16", got[16], 32'h61626380);
    chk("abc_w17", got[17], 32'h000F0000);
    chk("abc_w18", got[18], 32'h7DA86405);
    chk("abc_w19", got[19], 32'h600003C6);
    rand_block();
    model(blk, exp_w);
    load_block(blk, 0);
    drain(exp_w, 1, 64);
    rand_block();
    model(blk, exp_w);
    load_block(blk, 1);
    drain(exp_w, 1, 64);
    foreach (blk[i]) blk[i] = 32'hFFFFFFFF;
    model(blk, exp_w);
    load_block(blk, 0);
    drain(exp_w, 0, 64);
    rand_block();
    model(blk, exp_w);
    load_block(blk, 0);
    drain(exp_w, 0, 20);
    reset_n = 0;
    #1;
    chk("mid_rst_ir", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_index", {26'd0, out_index}, 32'd0);
    chk("mid_rst_word", out_word, 32'd0);
    @(negedge clock);
    reset_n = 1;
    @(negedge clock);
    load_block(blk, 0);
    drain(exp_w, 1, 64);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
